button_event_decoder: RTL and testbench
=======================================

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter NUM_BUTTONS, default 16, number of debounced button lines.
REQ-003 SHALL have parameter LONG_PRESS_MS, default 500, hold time before a long-press event.
REQ-004 SHALL have parameter REPEAT_MS, default 100, auto-repeat period after a long press.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port btn_level  input  NUM_BUTTONS  debounced, already-synchronous button levels (1 = pressed).
REQ-008 SHALL have port press_pulse  output  NUM_BUTTONS  one-cycle press strobes.
REQ-009 SHALL have port release_pulse  output  NUM_BUTTONS  one-cycle release strobes.
REQ-010 SHALL have port evt_valid  output  1  queued event available.
REQ-011 SHALL have port evt_ready  input  1  consumer accepts the event.
REQ-012 SHALL have port evt_id  output  $clog2(NUM_BUTTONS)  button index of the presented event.
REQ-013 SHALL have port evt_code  output  2  event type: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
REQ-014 SHALL have port evt_overflow  output  1  sticky flag: an event was lost.

Function
REQ-015 SHALL generate a 1 ms tick: prescaler 0..CLK_FREQ/1000-1, tick high for one cycle when the prescaler equals its maximum.
REQ-016 SHALL run one FSM per button with states IDLE, PRESSED, HELD.
REQ-017 SHALL register the previous level per button; a 0->1 transition in IDLE SHALL enter PRESSED, clear the hold counter, and drive press_pulse[i] high in the next cycle (1-cycle latency).
REQ-018 SHALL increment the hold counter on each tick in PRESSED; on reaching LONG_PRESS_MS it SHALL emit LONG, enter HELD, and clear the counter.
REQ-019 In HELD, on each counter reaching REPEAT_MS, SHALL emit REPEAT and clear the counter.
REQ-020 A 1->0 transition in PRESSED or HELD SHALL drive release_pulse[i] high in the next cycle and return to IDLE; if the release and a threshold coincide, release wins and no LONG/REPEAT is emitted.
REQ-021 SHALL keep one pending bit per (button, code); each event sets its bit at the clock edge ending the strobe cycle.
REQ-022 If an event targets a bit that is already set and not being consumed that cycle, SHALL set evt_overflow; the bit stays set, so the event is counted once.
REQ-023 When evt_valid is low, SHALL present the lowest-index button with any pending bit, code priority PRESS<RELEASE<LONG<REPEAT; evt_valid rises the cycle after the bit is set.
REQ-024 SHALL hold evt_valid, evt_id, and evt_code stable until evt_valid&&evt_ready; on handshake SHALL clear that pending bit and present the next pending event on the following cycle (evt_valid low one cycle).
REQ-025 If a bit is consumed and set again in the same cycle, SHALL keep it set and SHALL NOT flag overflow.
REQ-026 Hold counter width SHALL be $clog2(max(LONG_PRESS_MS,REPEAT_MS)+1); counters SHALL never wrap.

Reset
REQ-027 On rst, SHALL set all FSMs to IDLE, clear prescaler, counters, and pending bits, and load previous-level registers from 0.
REQ-028 On rst, SHALL drive press_pulse, release_pulse, evt_valid, evt_id, evt_code, and evt_overflow to 0.
REQ-029 Reset mid-hold SHALL abort the hold silently; a button still held after reset SHALL produce PRESS on the cycle after rst deasserts.

Structure
REQ-030 SHALL place the state enum, the evt_code enum, and the ms-divider constant function in package button_event_pkg.
REQ-031 SHALL implement the per-button FSM and hold counter as sub-module button_event_fsm, instantiated NUM_BUTTONS times; the prescaler and arbiter stay at top level.

Verification (CLK_FREQ=10_000 so tick every 10 clk, NUM_BUTTONS=4, LONG_PRESS_MS=5, REPEAT_MS=2)
REQ-032 Tap: btn_level[2] high 30 clk, evt_ready=1 -> press_pulse[2] one cycle after rise; events (2,PRESS) then (2,RELEASE); no LONG.
REQ-033 Hold: btn_level[1] high 120 clk -> (1,PRESS), (1,LONG) after 5 ticks, REPEAT every 2 ticks (3 REPEATs), then (1,RELEASE).
REQ-034 Simultaneous: btn 3 and btn 0 rise on the same cycle, evt_ready=0 for 5 clk -> (0,PRESS) held stable, then (3,PRESS) after the handshake.
REQ-035 Overflow: evt_ready=0, tap btn 0 twice -> evt_overflow=1 after the second PRESS; only one (0,PRESS) is delivered.
REQ-036 Reset: assert rst at tick 3 of a btn 1 hold, release rst with btn still high -> no LONG from the old hold; new PRESS one cycle after rst deasserts; all outputs 0 during rst.

Source files
------------

// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event decoder.
//
// btn_state_e  : per-button FSM state encoding
// evt_code_e   : event type presented on evt_code (PRESS/RELEASE/LONG/REPEAT)
// NUM_CODES    : number of event codes, one pending bit each per button
// ms_divider() : system clocks per 1 ms tick
// max_int()    : helper used when sizing the hold counter
package button_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'd0,
        EVT_RELEASE = 2'd1,
        EVT_LONG    = 2'd2,
        EVT_REPEAT  = 2'd3
    } evt_code_e;

    localparam int NUM_CODES = 4;

    function automatic int ms_divider(input int clk_freq);
        return clk_freq / 1000;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_fsm.sv
// Per-button press/long-press/auto-repeat tracker.
//
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   tick_i   : one-cycle 1 ms strobe from the shared prescaler
//   level_i  : debounced button level (1 = pressed)
//   evt_o    : one-cycle event strobes, indexed by evt_code_e
//              (bit 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT)
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | button released, waiting for a 0->1 edge
// ST_PRESSED | button down, counting ms ticks toward the long-press
// ST_HELD    | long press reached, emitting REPEAT every REPEAT_MS
module button_event_fsm
    import button_event_pkg::*;
#(
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_i,
    input  logic                 level_i,
    output logic [NUM_CODES-1:0] evt_o
);

    localparam int CNT_W = $clog2(max_int(LONG_PRESS_MS, REPEAT_MS) + 1);

    btn_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 prev_q;
    logic [NUM_CODES-1:0] evt_q, evt_d;
    logic                 rise, fall;

    assign rise  = level_i & ~prev_q;
    assign fall  = ~level_i & prev_q;
    assign evt_o = evt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_i;
            evt_q   <= evt_d;
        end
    end

    // The threshold test uses count-1 so the counter is cleared instead of
    // ever holding the threshold value itself; it cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        evt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d            = ST_PRESSED;
                    cnt_d              = '0;
                    evt_d[EVT_PRESS]   = 1'b1;
                end
            end
            ST_PRESSED: begin
                // Release takes priority over a coinciding threshold.
                if (fall) begin
                    state_d            = ST_IDLE;
                    cnt_d              = '0;
                    evt_d[EVT_RELEASE] = 1'b1;
                end else if (tick_i) begin
                    if (cnt_q == CNT_W'(LONG_PRESS_MS - 1)) begin
                        state_d         = ST_HELD;
                        cnt_d           = '0;
                        evt_d[EVT_LONG] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d            = ST_IDLE;
                    cnt_d              = '0;
                    evt_d[EVT_RELEASE] = 1'b1;
                end else if (tick_i) begin
                    if (cnt_q == CNT_W'(REPEAT_MS - 1)) begin
                        cnt_d             = '0;
                        evt_d[EVT_REPEAT] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_event_decoder.sv
// Button event decoder: turns debounced button levels into press/release
// strobes and a queued event stream (PRESS, RELEASE, LONG, REPEAT).
//
// Ports:
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset
//   btn_level     : debounced, synchronous button levels (1 = pressed)
//   press_pulse   : one-cycle press strobe per button
//   release_pulse : one-cycle release strobe per button
//   evt_valid     : an event is presented on evt_id/evt_code
//   evt_ready     : consumer accepts the presented event
//   evt_id        : button index of the presented event
//   evt_code      : 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   evt_overflow  : sticky, set when an event hit an already-pending bit
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int NUM_BUTTONS   = 16,
    parameter int LONG_PRESS_MS = 500,
    parameter int REPEAT_MS     = 100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_BUTTONS-1:0]         btn_level,
    output logic [NUM_BUTTONS-1:0]         press_pulse,
    output logic [NUM_BUTTONS-1:0]         release_pulse,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [$clog2(NUM_BUTTONS)-1:0] evt_id,
    output logic [1:0]                     evt_code,
    output logic                           evt_overflow
);

    localparam int DIV  = ms_divider(CLK_FREQ);
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ID_W = $clog2(NUM_BUTTONS);

    // ------------------------------------------------------------------
    // 1 ms prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = (presc_q == PW'(DIV - 1));

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-button FSMs
    // ------------------------------------------------------------------
    logic [NUM_CODES-1:0] evt_s [NUM_BUTTONS];

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        button_event_fsm #(
            .LONG_PRESS_MS (LONG_PRESS_MS),
            .REPEAT_MS     (REPEAT_MS)
        ) u_fsm (
            .clk     (clk),
            .rst     (rst),
            .tick_i  (tick),
            .level_i (btn_level[g]),
            .evt_o   (evt_s[g])
        );
        assign press_pulse[g]   = evt_s[g][EVT_PRESS];
        assign release_pulse[g] = evt_s[g][EVT_RELEASE];
    end

    // ------------------------------------------------------------------
    // Pending bits, overflow and presentation arbiter
    // ------------------------------------------------------------------
    logic [NUM_BUTTONS-1:0][NUM_CODES-1:0] pend_q, pend_d;
    logic                                  ovf_q, ovf_d;
    logic                                  valid_q, valid_d;
    logic [ID_W-1:0]                       id_q, id_d;
    evt_code_e                             code_q, code_d;
    logic                                  handshake;
    logic                                  consume;
    logic                                  found;

    assign handshake = valid_q & evt_ready;

    // A bit being consumed this cycle can be re-armed by a new event
    // without counting as a loss.
    always_comb begin
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        consume = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            for (int c = 0; c < NUM_CODES; c++) begin
                consume = handshake && (id_q == ID_W'(i)) && (code_q == 2'(c));
                if (evt_s[i][c] && pend_q[i][c] && !consume) begin
                    ovf_d = 1'b1;
                end
                pend_d[i][c] = (pend_q[i][c] & ~consume) | evt_s[i][c];
            end
        end
    end

    // The presented event is registered and only re-selected while idle,
    // so id/code stay frozen for the whole valid window.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        code_d  = code_q;
        found   = 1'b0;
        if (handshake) begin
            valid_d = 1'b0;
        end else if (!valid_q) begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                for (int c = 0; c < NUM_CODES; c++) begin
                    if (!found && pend_q[i][c]) begin
                        found   = 1'b1;
                        valid_d = 1'b1;
                        id_d    = ID_W'(i);
                        code_d  = evt_code_e'(2'(c));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= '0;
            code_q  <= EVT_PRESS;
        end else begin
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            code_q  <= code_d;
        end
    end

    assign evt_valid    = valid_q;
    assign evt_id       = id_q;
    assign evt_code     = code_q;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;
    import button_event_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [1:0] evt_code;
    logic       evt_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] evq[$];

    button_event_decoder #(
        .CLK_FREQ      (10_000),
        .NUM_BUTTONS   (4),
        .LONG_PRESS_MS (5),
        .REPEAT_MS     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_id        (evt_id),
        .evt_code      (evt_code),
        .evt_overflow  (evt_overflow)
    );

    always #5 clk = ~clk;

    // Inputs change only at posedge+1, so the negedge view equals the
    // value the DUT samples at the next posedge.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            evq.push_back({evt_id, evt_code});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input int idx, input logic [3:0] exp);
        logic [3:0] obs;
        obs = (idx < evq.size()) ? evq[idx] : 4'bxxxx;
        check(tag, {28'd0, obs}, {28'd0, exp});
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] ev(input int id, input int code);
        return {2'(id), 2'(code)};
    endfunction

    initial begin
        int k;
        rst       = 1'b1;
        btn_level = 4'b0000;
        evt_ready = 1'b0;
        step(3);

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_press",   {28'd0, press_pulse},   0);
        check("rst_release", {28'd0, release_pulse}, 0);
        check("rst_valid",   {31'd0, evt_valid},     0);
        check("rst_id",      {30'd0, evt_id},        0);
        check("rst_code",    {30'd0, evt_code},      0);
        check("rst_ovf",     {31'd0, evt_overflow},  0);
        step(1);
        rst = 1'b0;
        step(3);

        // ---------------- tap on button 2 ----------------
        evt_ready    = 1'b1;
        btn_level[2] = 1'b1;
        @(negedge clk);
        check("tap_press_same_cycle", {28'd0, press_pulse}, 4'b0000);
        @(negedge clk);
        check("tap_press_pulse", {28'd0, press_pulse}, 4'b0100);
        @(negedge clk);
        check("tap_press_one_cycle", {28'd0, press_pulse}, 4'b0000);
        check("tap_valid_not_yet", {31'd0, evt_valid}, 0);
        @(negedge clk);
        check("tap_valid_rise", {31'd0, evt_valid}, 1);
        check("tap_first_evt", {28'd0, evt_id, evt_code}, {28'd0, ev(2, 0)});
        @(posedge clk);
        repeat (26) @(posedge clk);
        #1 btn_level[2] = 1'b0;
        @(negedge clk);
        check("tap_release_same_cycle", {28'd0, release_pulse}, 4'b0000);
        @(negedge clk);
        check("tap_release_pulse", {28'd0, release_pulse}, 4'b0100);
        step(10);
        check("tap_count", evq.size(), 2);
        check_q("tap_ev0", 0, ev(2, EVT_PRESS));
        check_q("tap_ev1", 1, ev(2, EVT_RELEASE));
        evq.delete();

        // ---------------- hold on button 1 ----------------
        btn_level[1] = 1'b1;
        step(120);
        btn_level[1] = 1'b0;
        step(10);
        check("hold_count", evq.size(), 6);
        check_q("hold_ev0", 0, ev(1, EVT_PRESS));
        check_q("hold_ev1", 1, ev(1, EVT_LONG));
        check_q("hold_ev2", 2, ev(1, EVT_REPEAT));
        check_q("hold_ev3", 3, ev(1, EVT_REPEAT));
        check_q("hold_ev4", 4, ev(1, EVT_REPEAT));
        check_q("hold_ev5", 5, ev(1, EVT_RELEASE));
        check("hold_no_ovf", {31'd0, evt_overflow}, 0);
        evq.delete();

        // ---------------- simultaneous buttons 0 and 3 ----------------
        evt_ready = 1'b0;
        btn_level = 4'b1001;
        k = 0;
        @(negedge clk);
        while (!evt_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("sim_valid", {31'd0, evt_valid}, 1);
        check("sim_first", {28'd0, evt_id, evt_code}, {28'd0, ev(0, 0)});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sim_stable", {27'd0, evt_valid, evt_id, evt_code}, {27'd0, 1'b1, ev(0, 0)});
        end
        @(posedge clk);
        #1 evt_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 evt_ready = 1'b0;
        @(negedge clk);
        check("sim_gap", {31'd0, evt_valid}, 0);
        @(negedge clk);
        check("sim_second", {27'd0, evt_valid, evt_id, evt_code}, {27'd0, 1'b1, ev(3, 0)});
        step(1);
        btn_level = 4'b0000;
        evt_ready = 1'b1;
        step(12);
        check("sim_count", evq.size(), 4);
        check_q("sim_ev0", 0, ev(0, EVT_PRESS));
        check_q("sim_ev1", 1, ev(3, EVT_PRESS));
        check_q("sim_ev2", 2, ev(0, EVT_RELEASE));
        check_q("sim_ev3", 3, ev(3, EVT_RELEASE));
        evq.delete();

        // ---------------- overflow on button 0 ----------------
        evt_ready    = 1'b0;
        btn_level[0] = 1'b1;
        step(3);
        btn_level[0] = 1'b0;
        step(3);
        btn_level[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovf_before", {31'd0, evt_overflow}, 0);
        @(negedge clk);
        check("ovf_after_second_press", {31'd0, evt_overflow}, 1);
        step(1);
        btn_level[0] = 1'b0;
        step(4);
        @(negedge clk);
        check("ovf_presented", {27'd0, evt_valid, evt_id, evt_code}, {27'd0, 1'b1, ev(0, 0)});
        step(1);
        evt_ready = 1'b1;
        step(12);
        check("ovf_count", evq.size(), 2);
        check_q("ovf_ev0", 0, ev(0, EVT_PRESS));
        check_q("ovf_ev1", 1, ev(0, EVT_RELEASE));
        check("ovf_sticky", {31'd0, evt_overflow}, 1);
        evq.delete();

        // ---------------- reset during a hold on button 1 ----------------
        btn_level[1] = 1'b1;
        step(33);
        rst = 1'b1;
        evq.delete();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_outputs",
                  {18'd0, press_pulse, release_pulse, evt_valid, evt_id, evt_code, evt_overflow},
                  0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_press_not_yet", {28'd0, press_pulse}, 4'b0000);
        @(negedge clk);
        check("rst_press_after", {28'd0, press_pulse}, 4'b0010);
        repeat (38) @(posedge clk);
        #1 btn_level[1] = 1'b0;
        step(10);
        check("rst_count", evq.size(), 2);
        check_q("rst_ev0", 0, ev(1, EVT_PRESS));
        check_q("rst_ev1", 1, ev(1, EVT_RELEASE));
        check("rst_ovf_cleared", {31'd0, evt_overflow}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
